fir_mac_seq: RTL and testbench

Sequencer and multiply-accumulate engine that reads the addressable delay line in the FIR datapath. It accepts one input sample per filter run through a valid/ready handshake and shifts that sample into the delay line. It then sweeps the tap address over all `N_TAPS` positions, multiplying each delayed sample by the matching coefficient from an external coefficient store. The scaled and saturated result is presented on a valid/ready output port.

---
 rtl/fir_pkg.sv | 39 +++
 rtl/sat_shift.sv | 39 +++
 rtl/fir_mac_seq.sv | 105 ++++++++++
 tb/tb_fir_mac_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter stages: state encoding, default
// widths and arithmetic width helpers.
package fir_pkg;

    localparam int DEF_WIDTH_DATA    = 8;
    localparam int DEF_WIDTH_COEF    = 8;
    localparam int DEF_N_TAPS        = 16;
    localparam int DEF_WIDTH_MAC_OUT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_mac_state_t;

    // Sum of N products of WD x WC bits needs log2(N) guard bits.
    function automatic int acc_width(input int wd, input int wc, input int n_taps);
        return wd + wc + $clog2(n_taps);
    endfunction

    // Q1.(WC-1) coefficients: drop the fractional bits of the product sum.
    function automatic int shift_amount(input int wc);
        return wc - 1;
    endfunction

    function automatic int sat_max(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(2 ** (w - 1));
    endfunction

    localparam int DEF_ACC_WIDTH = acc_width(DEF_WIDTH_DATA, DEF_WIDTH_COEF, DEF_N_TAPS);
    localparam int DEF_SHIFT     = shift_amount(DEF_WIDTH_COEF);
    localparam int DEF_SAT_MAX   = sat_max(DEF_WIDTH_MAC_OUT);
    localparam int DEF_SAT_MIN   = sat_min(DEF_WIDTH_MAC_OUT);

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift (floor) followed by signed saturation
// to a narrower output width.
module sat_shift
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_WIDTH_MAC_OUT,
    parameter int SHIFT     = DEF_SHIFT
) (
    input  logic signed [IN_WIDTH-1:0]  in_val,
    output logic signed [OUT_WIDTH-1:0] out_val
);

    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

    logic signed [IN_WIDTH-1:0] shifted;

    assign shifted = in_val >>> SHIFT;

    generate
        if (IN_WIDTH > OUT_WIDTH) begin : g_sat
            // The value fits when every bit from the output sign bit upward agrees.
            logic [IN_WIDTH-OUT_WIDTH:0] top_bits;

            assign top_bits = shifted[IN_WIDTH-1:OUT_WIDTH-1];

            always_comb begin
                out_val = shifted[OUT_WIDTH-1:0];
                if (top_bits != '0 && top_bits != '1) begin
                    out_val = shifted[IN_WIDTH-1] ? SAT_MIN : SAT_MAX;
                end
            end
        end else begin : g_ext
            assign out_val = OUT_WIDTH'(shifted);
        end
    endgenerate

endmodule

// File: rtl/fir_mac_seq.sv
// FIR sequencer: accepts one sample per run, shifts it into the external
// delay line, then sweeps all taps through a single multiply-accumulate.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int WIDTH_DATA    = DEF_WIDTH_DATA,
    parameter int WIDTH_COEF    = DEF_WIDTH_COEF,
    parameter int N_TAPS        = DEF_N_TAPS,
    parameter int WIDTH_MAC_OUT = DEF_WIDTH_MAC_OUT
) (
    input  logic                              clk,
    input  logic                              clr_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [WIDTH_DATA-1:0]      in_data,
    output logic                              asr_en,
    output logic                              asr_clr,
    output logic signed [WIDTH_DATA-1:0]      asr_d,
    output logic [$clog2(N_TAPS)-1:0]         asr_add,
    input  logic signed [WIDTH_DATA-1:0]      asr_q,
    output logic [$clog2(N_TAPS)-1:0]         coef_add,
    input  logic signed [WIDTH_COEF-1:0]      coef,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [WIDTH_MAC_OUT-1:0]   out_data
);

    localparam int ADDR_W = $clog2(N_TAPS);
    localparam int ACC_W  = acc_width(WIDTH_DATA, WIDTH_COEF, N_TAPS);
    localparam int PROD_W = WIDTH_DATA + WIDTH_COEF;
    localparam int SHIFT  = shift_amount(WIDTH_COEF);
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

    fir_mac_state_t                  state_reg;
    logic [ADDR_W-1:0]               cnt_reg;
    logic signed [ACC_W-1:0]         acc_reg;
    logic signed [ACC_W-1:0]         acc_next;
    logic signed [PROD_W-1:0]        prod;
    logic signed [WIDTH_MAC_OUT-1:0] result;
    logic                            accept;

    // Handshake and delay-line strobes react to inputs within the cycle.
    assign in_ready = (state_reg == IDLE) && clr_n && !flush;
    assign accept   = in_valid && in_ready;
    assign asr_en   = accept;
    assign asr_clr  = (state_reg == IDLE) && clr_n && flush;
    assign asr_d    = in_data;

    // The counter is zero outside MAC, so the addresses idle at the newest tap.
    assign asr_add  = cnt_reg;
    assign coef_add = cnt_reg;

    assign prod     = asr_q * coef;
    assign acc_next = acc_reg + ACC_W'(prod);

    sat_shift #(
        .IN_WIDTH  (ACC_W),
        .OUT_WIDTH (WIDTH_MAC_OUT),
        .SHIFT     (SHIFT)
    ) u_sat_shift (
        .in_val  (acc_next),
        .out_val (result)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + ADDR_W'(1);
                    // Last tap: the saturated final sum is captured on the same edge.
                    if (cnt_reg == LAST_TAP) begin
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq with a behavioural delay line,
// coefficient store and a convolution reference model.
module tb_fir_mac_seq;

    localparam int NT = 16;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              asr_en;
    logic              asr_clr;
    logic signed [7:0] asr_d;
    logic [3:0]        asr_add;
    logic signed [7:0] asr_q;
    logic [3:0]        coef_add;
    logic signed [7:0] coef;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;

    logic signed [7:0] dl [NT];
    logic signed [7:0] coef_mem [NT];
    int                ref_hist [NT];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fir_mac_seq dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .asr_en    (asr_en),
        .asr_clr   (asr_clr),
        .asr_d     (asr_d),
        .asr_add   (asr_add),
        .asr_q     (asr_q),
        .coef_add  (coef_add),
        .coef      (coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Environment: addressable shift register and coefficient ROM.
    assign asr_q = dl[asr_add];
    assign coef  = coef_mem[coef_add];

    always @(posedge clk) begin
        if (asr_clr) begin
            for (int i = 0; i < NT; i++) dl[i] <= '0;
        end else if (asr_en) begin
            for (int i = NT - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= asr_d;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int ref_out();
        int s;
        s = 0;
        for (int i = 0; i < NT; i++) s += ref_hist[i] * int'(coef_mem[i]);
        s = s >>> 7;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic void ref_push(input int x);
        for (int i = NT - 1; i > 0; i--) ref_hist[i] = ref_hist[i-1];
        ref_hist[0] = x;
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < NT; i++) ref_hist[i] = 0;
    endfunction

    // One complete filter run; hold = cycles of output backpressure in DONE.
    task automatic run_sample(input logic signed [7:0] x, input int hold,
                              input bit flush_mac, output int got);
        int  n;
        int  exp_v;
        bit  strobe_bad;
        bit  hold_bad;
        logic signed [7:0] held;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept_wait", int'(n < 50), 1);
        check("asr_en_accept", int'(asr_en), 1);
        check("asr_d_accept", int'(asr_d), int'(x));
        ref_push(int'(x));
        exp_v = ref_out();

        @(negedge clk);
        in_valid = 1'(($urandom & 1));
        in_data  = 8'($urandom);
        flush    = flush_mac;
        #1;
        n = 1;
        strobe_bad = 1'b0;
        while (!out_valid && n < 40) begin
            if (asr_en || asr_clr) strobe_bad = 1'b1;
            @(negedge clk); #1;
            n++;
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        check("latency", n, NT + 1);
        check("no_stray_strobe", int'(strobe_bad), 0);
        check("out_data", int'(out_data), exp_v);
        got = int'(out_data);
        $display("run x=%0d out=%0d exp=%0d latency=%0d hold=%0d", x, out_data, exp_v, n, hold);

        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            held      = out_data;
            hold_bad  = 1'b0;
            repeat (hold) begin
                @(negedge clk); #1;
                if (!out_valid || out_data != held || in_ready || asr_en) hold_bad = 1'b1;
            end
            check("backpressure_hold", int'(hold_bad), 0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk); #1;
        check("in_ready_after_done", int'(in_ready), 1);
        check("out_valid_cleared", int'(out_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_asr_en"}, int'(asr_en), 0);
        check({tag, "_asr_clr"}, int'(asr_clr), 0);
        check({tag, "_asr_add"}, int'(asr_add), 0);
        check({tag, "_coef_add"}, int'(coef_add), 0);
        check({tag, "_asr_d"}, int'(asr_d), int'(in_data));
    endtask

    initial begin
        int got;
        logic signed [7:0] x;

        for (int i = 0; i < NT; i++) begin
            dl[i]       = '0;
            coef_mem[i] = '0;
        end
        ref_clear();
        clr_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'sh5A;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clr_n    = 1'b1;

        // Impulse response
        for (int i = 0; i < NT; i++) coef_mem[i] = 8'(2 * (i + 1));
        for (int i = 0; i < NT + 2; i++) begin
            x = (i == 0) ? 8'sd64 : 8'sd0;
            run_sample(x, 0, 1'b0, got);
            check("impulse_tap", got, (i < NT) ? i + 1 : 0);
        end

        // Positive saturation
        for (int i = 0; i < NT; i++) coef_mem[i] = 8'sd127;
        for (int i = 0; i < NT; i++) run_sample(8'sd127, 0, 1'b0, got);
        check("pos_sat", got, 127);

        // Negative saturation
        for (int i = 0; i < NT; i++) run_sample(-8'sd128, 0, 1'b0, got);
        check("neg_sat", got, -128);

        // Floor of a negative fraction
        for (int i = 0; i < NT; i++) coef_mem[i] = '0;
        coef_mem[0] = 8'sd1;
        run_sample(-8'sd1, 0, 1'b0, got);
        check("floor_neg", got, -1);

        // Backpressure
        for (int i = 0; i < NT; i++) coef_mem[i] = 8'($urandom);
        run_sample(8'($urandom), 5, 1'b0, got);

        // Flush in IDLE while a sample is offered
        for (int i = 0; i < 4; i++) run_sample(8'($urandom), 0, 1'b0, got);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        #1;
        check("flush_asr_clr", int'(asr_clr), 1);
        check("flush_asr_en", int'(asr_en), 0);
        check("flush_in_ready", int'(in_ready), 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        ref_clear();
        run_sample(8'sd0, 0, 1'b0, got);
        check("after_flush_zero", got, 0);

        // Flush during MAC is ignored
        for (int i = 0; i < 3; i++) run_sample(8'($urandom), 0, 1'b0, got);
        run_sample(8'($urandom), 0, 1'b1, got);
        run_sample(8'($urandom), 0, 1'b0, got);

        // Reset in the middle of a run
        @(negedge clk);
        x        = 8'($urandom);
        in_valid = 1'b1;
        in_data  = x;
        #1;
        check("mid_reset_accept", int'(in_ready && asr_en), 1);
        ref_push(int'(x));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        check("mid_reset_cnt7", int'(asr_add), 7);
        clr_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        run_sample(8'($urandom), 0, 1'b0, got);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            if (r % 5 == 0) begin
                for (int i = 0; i < NT; i++) coef_mem[i] = 8'($urandom);
            end
            run_sample(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom & 1), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
